// File: rtl/frame_buffer_1bpc_pkg.sv
// Shared types and constants for the double-buffered 1bpc frame buffer.
// The optional FB_AUTO_CLEAR_EN build clears the new back bank after each swap.
package frame_buffer_1bpc_pkg;

  localparam int FB_COL_BITS  = 6;
  localparam int FB_LINE_BITS = 5;

  localparam int R1 = 5;
  localparam int G1 = 4;
  localparam int B1 = 3;
  localparam int R2 = 2;
  localparam int G2 = 1;
  localparam int B2 = 0;

  typedef enum logic {
    FB_IDLE  = 1'b0,
    FB_CLEAR = 1'b1
  } fb_state_e;

endpackage

// File: rtl/frame_buffer_1bpc_bank_ram.sv
// One 3-bit pixel array: synchronous write, registered read.
// Written so synthesis maps it onto a single block RAM.
module fb_bank_ram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [2:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [2:0]    rdata
);

  logic [2:0] mem_q [2**AW];
  logic [2:0] rdata_q;
  logic [2:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frame_buffer_1bpc.sv
// Double-buffered 1bpc pixel store for the HUB75 driver, swap at frame end.
// Define FB_AUTO_CLEAR_EN to zero the new back bank after every swap.
module frame_buffer_1bpc
  import frame_buffer_1bpc_pkg::*;
#(
  parameter int COL_BITS  = FB_COL_BITS,
  parameter int LINE_BITS = FB_LINE_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_en,
  input  logic [LINE_BITS-1:0] rd_line,
  input  logic [COL_BITS-1:0]  rd_column,
  output logic [5:0]           rd_rgb,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [COL_BITS-1:0]  wr_x,
  input  logic [LINE_BITS:0]   wr_y,
  input  logic [2:0]           wr_rgb,
  input  logic                 clear_req,
  output logic                 busy,
  input  logic                 swap_req,
  input  logic                 frame_end,
  output logic                 swap_pending,
  output logic                 front_bank
);

  localparam int AW = LINE_BITS + COL_BITS;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CLR_LAST = CW'((2**AW) - 1);

  fb_state_e     state_q, state_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic          front_q, front_d;
  logic          pend_q, pend_d;
  logic          rd_sel_q, rd_sel_d;
  logic          do_swap;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    front_d   = front_q;
    pend_d    = pend_q;
    unique case (state_q)
      FB_IDLE: begin
        if (clear_req) begin
          state_d   = FB_CLEAR;
          clr_cnt_d = '0;
        end
      end
      FB_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d   = FB_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CW'(1);
        end
      end
      default: state_d = FB_IDLE;
    endcase
    // a clear starting this cycle keeps the request pending
    do_swap = frame_end && (state_q == FB_IDLE) && !clear_req
           && (pend_q || swap_req);
    if (do_swap) begin
      front_d = ~front_q;
      pend_d  = 1'b0;
`ifdef FB_AUTO_CLEAR_EN
      state_d   = FB_CLEAR;
      clr_cnt_d = '0;
`endif
    end else if (swap_req) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FB_IDLE;
      clr_cnt_q <= '0;
      front_q   <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      front_q   <= front_d;
      pend_q    <= pend_d;
    end
  end

  logic          clearing;
  logic          back;
  logic          wr_fire;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [2:0]    wdata;
  logic [1:0][1:0] we;

  always_comb begin
    clearing = (state_q == FB_CLEAR);
    back     = ~front_q;
    wr_fire  = wr_valid && !clearing;
    waddr    = clearing ? clr_cnt_q[AW-1:0]
                        : {wr_y[LINE_BITS-1:0], wr_x};
    wdata    = clearing ? 3'b000 : wr_rgb;
    raddr    = {rd_line, rd_column};
    we       = '0;
    for (int b = 0; b < 2; b++) begin
      for (int h = 0; h < 2; h++) begin
        we[b][h] = (1'(b) == back)
                && (clearing
                    || (wr_fire && (1'(h) == wr_y[LINE_BITS])));
      end
    end
  end

  logic [2:0] rdata [2][2];

  for (genvar gb = 0; gb < 2; gb++) begin : g_bank
    for (genvar gh = 0; gh < 2; gh++) begin : g_half
      fb_bank_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we[gb][gh]),
        .waddr (waddr),
        .wdata (wdata),
        .re    (rd_en),
        .raddr (raddr),
        .rdata (rdata[gb][gh])
      );
    end
  end

  // remember which bank the registered read data came from
  always_comb begin
    rd_sel_d = rd_sel_q;
    if (rd_en) rd_sel_d = front_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_sel_q <= 1'b0;
    else        rd_sel_q <= rd_sel_d;
  end

  logic [2:0] rd_top, rd_bot;

  always_comb begin
    rd_top     = rdata[rd_sel_q][0];
    rd_bot     = rdata[rd_sel_q][1];
    rd_rgb     = '0;
    rd_rgb[R1] = rd_top[2];
    rd_rgb[G1] = rd_top[1];
    rd_rgb[B1] = rd_top[0];
    rd_rgb[R2] = rd_bot[2];
    rd_rgb[G2] = rd_bot[1];
    rd_rgb[B2] = rd_bot[0];
  end

  assign busy         = (state_q == FB_CLEAR);
  assign wr_ready     = (state_q == FB_IDLE);
  assign swap_pending = pend_q;
  assign front_bank   = front_q;

endmodule

// File: tb/tb_frame_buffer_1bpc.sv
// Scoreboard bench for frame_buffer_1bpc: model banks, queue of expected reads.
// Honours FB_AUTO_CLEAR_EN the same way as the design.
module tb_frame_buffer_1bpc;

  localparam int DEPTH = 2048;

  logic       clk;
  logic       rst_n;
  logic       rd_en;
  logic [4:0] rd_line;
  logic [5:0] rd_column;
  logic [5:0] rd_rgb;
  logic       wr_valid;
  logic       wr_ready;
  logic [5:0] wr_x;
  logic [5:0] wr_y;
  logic [2:0] wr_rgb;
  logic       clear_req;
  logic       busy;
  logic       swap_req;
  logic       frame_end;
  logic       swap_pending;
  logic       front_bank;

  frame_buffer_1bpc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en        (rd_en),
    .rd_line      (rd_line),
    .rd_column    (rd_column),
    .rd_rgb       (rd_rgb),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_rgb       (wr_rgb),
    .clear_req    (clear_req),
    .busy         (busy),
    .swap_req     (swap_req),
    .frame_end    (frame_end),
    .swap_pending (swap_pending),
    .front_bank   (front_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  logic [2:0] m [2][2][DEPTH];
  bit         front_m;
  logic [5:0] sb [$];

  function automatic logic [5:0] exp_rd(input int line, input int col);
    int a;
    a = line * 64 + col;
    return {m[front_m][0][a], m[front_m][1][a]};
  endfunction

  task automatic clr_model(input bit b);
    for (int i = 0; i < DEPTH; i++) begin
      m[b][0][i] = 3'b000;
      m[b][1][i] = 3'b000;
    end
  endtask

  always @(posedge clk) begin
    if (rd_en) begin
      #1;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else                chk("rd_rgb", rd_rgb, sb.pop_front());
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int exp_n);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    while (busy && n < 5000) begin
      if (wr_ready) bad++;
      step();
      n++;
    end
    chk({tag, "_len"}, n, exp_n);
    chk({tag, "_rdy"}, bad, 0);
  endtask

  task automatic do_clear();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    clr_model(!front_m);
    wait_idle("clr", 2048);
  endtask

  task automatic after_swap();
    chk("front", front_bank, front_m);
    chk("pend_clr", swap_pending, 0);
`ifdef FB_AUTO_CLEAR_EN
    chk("auto_busy", busy, 1);
    clr_model(!front_m);
    wait_idle("auto", 2048);
`else
    chk("no_auto_busy", busy, 0);
`endif
  endtask

  task automatic do_swap();
    swap_req  = 1'b1;
    frame_end = 1'b1;
    step();
    swap_req  = 1'b0;
    frame_end = 1'b0;
    front_m   = !front_m;
    after_swap();
  endtask

  task automatic wr_px(input int x, input logic [5:0] y,
                       input logic [2:0] rgb);
    wr_valid = 1'b1;
    wr_x     = 6'(x);
    wr_y     = y;
    wr_rgb   = rgb;
    chk("wr_ready", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    m[!front_m][y[5]][int'(y[4:0]) * 64 + x] = rgb;
  endtask

  task automatic rd_px(input int line, input int col);
    rd_en     = 1'b1;
    rd_line   = 5'(line);
    rd_column = 6'(col);
    sb.push_back(exp_rd(line, col));
    step();
    rd_en = 1'b0;
  endtask

  task automatic rd_all();
    for (int i = 0; i < DEPTH; i++) begin
      rd_en     = 1'b1;
      rd_line   = 5'(i / 64);
      rd_column = 6'(i % 64);
      sb.push_back(exp_rd(i / 64, i % 64));
      step();
    end
    rd_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    rd_en     = 1'b0;
    rd_line   = '0;
    rd_column = '0;
    wr_valid  = 1'b0;
    wr_x      = '0;
    wr_y      = '0;
    wr_rgb    = '0;
    clear_req = 1'b0;
    swap_req  = 1'b0;
    frame_end = 1'b0;
    front_m   = 1'b0;
    clr_model(1'b0);
    clr_model(1'b1);
    repeat (3) step();
    chk("rst_rd_rgb", rd_rgb, 0);
    chk("rst_front", front_bank, 0);
    chk("rst_pend", swap_pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ready", wr_ready, 1);
    rst_n = 1'b1;
    step();

    // clear bank 1, show it, clear bank 0, read every address
    do_clear();
    do_swap();
    do_clear();
    rd_all();

    // one pixel per half at the same line/column
    wr_px(5, 6'd3, 3'b101);
    wr_px(5, 6'd35, 3'b011);
    do_swap();
    rd_px(3, 5);
    chk("px_const", rd_rgb, 6'b101011);
    repeat (3) step();
    chk("rd_hold", rd_rgb, 6'b101011);

    // request waits for a frame boundary
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    repeat (999) step();
    chk("wait_pend", swap_pending, 1);
    chk("wait_front", front_bank, front_m);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    front_m   = !front_m;
    after_swap();

    // write + read + swap in one cycle
    wr_valid  = 1'b1;
    wr_x      = 6'd10;
    wr_y      = 6'd7;
    wr_rgb    = 3'b110;
    rd_en     = 1'b1;
    rd_line   = 5'd7;
    rd_column = 6'd10;
    swap_req  = 1'b1;
    frame_end = 1'b1;
    chk("sim_wr_ready", wr_ready, 1);
    sb.push_back(exp_rd(7, 10));
    step();
    wr_valid  = 1'b0;
    rd_en     = 1'b0;
    swap_req  = 1'b0;
    frame_end = 1'b0;
    m[!front_m][0][7 * 64 + 10] = 3'b110;
    front_m = !front_m;
    after_swap();
    rd_px(7, 10);
    chk("swap_wr_px", rd_rgb[5:3], 3'b110);

    // swap + clear together, frame_end mid-clear is ignored
    swap_req  = 1'b1;
    clear_req = 1'b1;
    step();
    swap_req  = 1'b0;
    clear_req = 1'b0;
    clr_model(!front_m);
    chk("mid_pend0", swap_pending, 1);
    chk("mid_busy0", busy, 1);
    repeat (99) step();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    chk("mid_front", front_bank, front_m);
    chk("mid_pend", swap_pending, 1);
    wait_idle("clr_mid", 1948);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    front_m   = !front_m;
    after_swap();
    rd_px(7, 10);

    // second swap: old contents come back unless auto-cleared
    do_swap();
    rd_px(7, 10);
    rd_px(3, 5);
    rd_all();

    step();
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
